// File: rtl/capture_pkg.sv
// Shared types and width helpers for the AXI4-Stream frame capture block.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } cap_state_t;

  // Address width for a buffer of the given depth.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counter width able to hold the value depth itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_frame_capture_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module sdp_ram
  import capture_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; contents persist across captures and resets.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-address write in this cycle returns the old word.
  always_ff @(posedge clk) begin
    if (!aresetn) rdata <= '0;
    else          rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_frame_capture.sv
// AXI4-Stream snapshot buffer: arms on command, optionally aligns to a tlast
// boundary, captures DEPTH beats, checks framing, and offers readback.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | after reset; waits for arm (or the automatic arm)
//  WAIT_SOF | discards beats until a tlast beat, then starts capture
//  CAPTURE  | each beat writes ram[count]; framing checked per beat
//  DONE     | buffer full; waits for arm to recapture
module axis_frame_capture
  import capture_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int FRAME_LEN    = 32,
  parameter bit ALIGN_TLAST  = 1'b1,
  parameter bit BACKPRESSURE = 1'b1,
  parameter bit AUTO_ARM     = 1'b0,
  localparam int AW = addr_w(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic             arm,
  output logic             busy,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    frame_cnt,
  output logic             frame_err,
  output logic             overflow,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  cap_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pos_q, pos_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic          auto_pend_q;
  logic          arm_eff;
  logic          beat;
  logic          we;

  // Next-state, counter and flag logic; pos tracks count mod FRAME_LEN.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pos_d   = pos_q;
    fcnt_d  = fcnt_q;
    ferr_d  = ferr_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    arm_eff = arm | auto_pend_q;
    if (BACKPRESSURE) s_axis_tready = (state_q == WAIT_SOF) || (state_q == CAPTURE);
    else              s_axis_tready = 1'b1;
    beat = s_axis_tvalid & s_axis_tready;
    case (state_q)
      IDLE, DONE: begin
        if (arm_eff) begin
          count_d = '0;
          pos_d   = '0;
          fcnt_d  = '0;
          ferr_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ALIGN_TLAST ? WAIT_SOF : CAPTURE;
        end else if (state_q == DONE && !BACKPRESSURE && s_axis_tvalid) begin
          ovf_d = 1'b1;
        end
      end
      WAIT_SOF: begin
        if (beat && s_axis_tlast) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (beat) begin
          we      = 1'b1;
          count_d = count_q + CW'(1);
          if (pos_q == CW'(FRAME_LEN - 1)) begin
            pos_d = '0;
            if (s_axis_tlast) fcnt_d = fcnt_q + CW'(1);
            else              ferr_d = 1'b1;
          end else begin
            pos_d = pos_q + CW'(1);
            if (s_axis_tlast) ferr_d = 1'b1;
          end
          if (count_q == CW'(DEPTH - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; auto-arm fires once after reset release.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pos_q       <= '0;
      fcnt_q      <= '0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      auto_pend_q <= AUTO_ARM;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pos_q       <= pos_d;
      fcnt_q      <= fcnt_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
      auto_pend_q <= 1'b0;
    end
  end

  assign busy      = (state_q == WAIT_SOF) || (state_q == CAPTURE);
  assign full      = (state_q == DONE);
  assign count     = count_q;
  assign frame_cnt = fcnt_q;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

  sdp_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .aresetn(aresetn),
    .we     (we),
    .waddr  (count_q[AW-1:0]),
    .wdata  (s_axis_tdata),
    .raddr  (rd_addr),
    .rdata  (rd_data)
  );

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench: instance A (auto-arm, no alignment, backpressure) and
// instance B (tlast alignment, no backpressure) sharing clock and reset.
module tb_axis_frame_capture;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int FL = 8;
  localparam int CW = 6;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic aresetn;

  logic [W-1:0]  a_tdata, a_rdata, b_tdata, b_rdata;
  logic          a_tvalid, a_tready, a_tlast, a_arm, a_busy, a_full, a_ferr, a_ovf;
  logic          b_tvalid, b_tready, b_tlast, b_arm, b_busy, b_full, b_ferr, b_ovf;
  logic [CW-1:0] a_count, a_fcnt, b_count, b_fcnt;
  logic [AW-1:0] a_raddr, b_raddr;

  axis_frame_capture #(.WIDTH(W), .DEPTH(D), .FRAME_LEN(FL), .ALIGN_TLAST(1'b0),
                       .BACKPRESSURE(1'b1), .AUTO_ARM(1'b1)) dut_a (
    .clk(clk), .aresetn(aresetn), .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid),
    .s_axis_tready(a_tready), .s_axis_tlast(a_tlast), .arm(a_arm), .busy(a_busy),
    .full(a_full), .count(a_count), .frame_cnt(a_fcnt), .frame_err(a_ferr),
    .overflow(a_ovf), .rd_addr(a_raddr), .rd_data(a_rdata));

  axis_frame_capture #(.WIDTH(W), .DEPTH(D), .FRAME_LEN(FL), .ALIGN_TLAST(1'b1),
                       .BACKPRESSURE(1'b0), .AUTO_ARM(1'b0)) dut_b (
    .clk(clk), .aresetn(aresetn), .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid),
    .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .arm(b_arm), .busy(b_busy),
    .full(b_full), .count(b_count), .frame_cnt(b_fcnt), .frame_err(b_ferr),
    .overflow(b_ovf), .rd_addr(b_raddr), .rd_data(b_rdata));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen within cycle budget", nm);
  endtask

  task automatic rd_a(input int addr, output logic [W-1:0] data);
    a_raddr = AW'(addr);
    @(posedge clk); #1;
    data = a_rdata;
  endtask

  task automatic rd_b(input int addr, output logic [W-1:0] data);
    b_raddr = AW'(addr);
    @(posedge clk); #1;
    data = b_rdata;
  endtask

  // Arm B, then stream 39 beats numbered n with tdata=base+n; tlast on n%8==3.
  task automatic run_capture(input int base, input int skip, input int extra, input bit arm_last);
    @(posedge clk); #1;
    b_arm = 1'b1; b_tvalid = 1'b0; b_tlast = 1'b0;
    @(posedge clk); #1;
    b_arm = 1'b0;
    @(negedge clk);
    check("b_arm_busy", b_busy, 1);
    check("b_arm_full", b_full, 0);
    check("b_arm_count", b_count, 0);
    check("b_arm_fcnt", b_fcnt, 0);
    check("b_arm_ferr", b_ferr, 0);
    check("b_arm_ovf", b_ovf, 0);
    for (int n = 0; n < 39; n++) begin
      @(posedge clk); #1;
      b_tdata  = W'(base + n);
      b_tvalid = 1'b1;
      b_tlast  = (((n % 8) == 3) && (n != skip)) || (n == extra);
      b_arm    = arm_last && (n == 35);
      @(negedge clk);
      if (n == 35) check("b_full_on_last", b_full, 0);
      if (n == 36) check("b_full_after_last", b_full, 1);
    end
    @(posedge clk); #1;
    b_tvalid = 1'b0; b_tlast = 1'b0; b_arm = 1'b0;
  endtask

  typedef struct {
    int skip;
    int extra;
    bit arm_last;
    int base;
    int exp_fcnt;
    bit exp_err;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d;
    bit hs, exp_full_next, full_ok, got;
    logic [W-1:0] rv;

    tbl[0] = '{skip: -1, extra: -1, arm_last: 1'b0, base: 0,   exp_fcnt: 4, exp_err: 1'b0};
    tbl[1] = '{skip: 27, extra: -1, arm_last: 1'b0, base: 100, exp_fcnt: 3, exp_err: 1'b1};
    tbl[2] = '{skip: -1, extra: 13, arm_last: 1'b0, base: 200, exp_fcnt: 4, exp_err: 1'b1};
    tbl[3] = '{skip: 35, extra: -1, arm_last: 1'b1, base: 300, exp_fcnt: 3, exp_err: 1'b1};

    aresetn = 1'b0;
    a_tdata = '0; a_tvalid = 1'b0; a_tlast = 1'b0; a_arm = 1'b0; a_raddr = '0;
    b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0; b_arm = 1'b0; b_raddr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_busy", a_busy, 0);   check("rst_a_full", a_full, 0);
    check("rst_a_count", a_count, 0); check("rst_a_fcnt", a_fcnt, 0);
    check("rst_a_ferr", a_ferr, 0);   check("rst_a_ovf", a_ovf, 0);
    check("rst_a_rdata", a_rdata, 0); check("rst_b_busy", b_busy, 0);
    check("rst_b_full", b_full, 0);   check("rst_b_count", b_count, 0);

    // A: auto-arm after release, ramp source with tlast every 8th beat.
    @(posedge clk); #1;
    aresetn = 1'b1; a_tvalid = 1'b1; a_tdata = '0; a_tlast = 1'b0;
    d = 0; exp_full_next = 1'b0; full_ok = 1'b0;
    for (int cyc = 0; cyc < 200 && !full_ok; cyc++) begin
      @(negedge clk);
      if (exp_full_next) begin
        check("a_full_rise", a_full, 1);
        check("a_tready_after_full", a_tready, 0);
        full_ok = 1'b1;
      end
      hs = a_tvalid && a_tready;
      if (hs && d == 31) begin
        check("a_full_before_last", a_full, 0);
        exp_full_next = 1'b1;
      end
      @(posedge clk); #1;
      if (hs && d < 40) begin
        d++;
        a_tdata = W'(d);
        a_tlast = ((d % 8) == 7);
      end
    end
    if (!full_ok) timeout("a_full_timeout");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_count", a_count, 32);
    check("a_fcnt", a_fcnt, 4);
    check("a_ferr", a_ferr, 0);
    check("a_tready_done", a_tready, 0);
    check("a_busy_done", a_busy, 0);
    check("a_full_hold", a_full, 1);
    a_tvalid = 1'b0;
    for (int i = 0; i < D; i++) begin
      rd_a(i, rv);
      check($sformatf("a_ram_%0d", i), rv, i);
    end

    // B: framing variants, overflow in DONE, arm coincident with final beat.
    for (int v = 0; v < 4; v++) begin
      run_capture(tbl[v].base, tbl[v].skip, tbl[v].extra, tbl[v].arm_last);
      @(negedge clk);
      check($sformatf("b%0d_full", v), b_full, 1);
      check($sformatf("b%0d_busy", v), b_busy, 0);
      check($sformatf("b%0d_count", v), b_count, 32);
      check($sformatf("b%0d_fcnt", v), b_fcnt, tbl[v].exp_fcnt);
      check($sformatf("b%0d_ferr", v), b_ferr, tbl[v].exp_err);
      check($sformatf("b%0d_ovf", v), b_ovf, 1);
      check($sformatf("b%0d_tready", v), b_tready, 1);
      rd_b(0, rv);  check($sformatf("b%0d_ram0", v), rv, tbl[v].base + 4);
      rd_b(23, rv); check($sformatf("b%0d_ram23", v), rv, tbl[v].base + 27);
      rd_b(31, rv); check($sformatf("b%0d_ram31", v), rv, tbl[v].base + 35);
    end

    // B: reset mid-capture at count 10, then a fresh capture from ram[0].
    @(posedge clk); #1; b_arm = 1'b1;
    @(posedge clk); #1; b_arm = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(posedge clk); #1;
      b_tdata = W'(400 + n); b_tvalid = 1'b1; b_tlast = ((n % 8) == 3);
      @(negedge clk);
      if (b_count == CW'(10)) got = 1'b1;
    end
    if (!got) timeout("b_count10_timeout");
    @(posedge clk); #1;
    aresetn = 1'b0; b_tvalid = 1'b0; b_tlast = 1'b0; b_raddr = '0;
    @(posedge clk); #1;
    check("b_rst_busy", b_busy, 0);   check("b_rst_full", b_full, 0);
    check("b_rst_count", b_count, 0); check("b_rst_fcnt", b_fcnt, 0);
    check("b_rst_ferr", b_ferr, 0);   check("b_rst_ovf", b_ovf, 0);
    check("b_rst_rdata", b_rdata, 0);
    aresetn = 1'b1;
    run_capture(500, -1, -1, 1'b0);
    @(negedge clk);
    check("b_recap_count", b_count, 32);
    check("b_recap_fcnt", b_fcnt, 4);
    rd_b(0, rv);  check("b_recap_ram0", rv, 504);
    rd_b(9, rv);  check("b_recap_ram9", rv, 513);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
